pxl_write_arbiter: RTL

Frame-atomic write scheduler that shares the frame-buffer pixel write port (pxl_addr/pxl_data/pxl_en of the ADV7511 HDMI controller) between NSRC AXI4-Stream video sources. It locks onto a source's start-of-frame, generates the linear pixel address, and hands the port to the next enabled source only after a complete frame. It replaces the free-running address counter in the board wrapper and sits between the video generators and the HDMI controller, in the pixel clock domain.

---
 rtl/pxl_write_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/pxl_write_arbiter.sv
// pxl_write_arbiter: frame-atomic round-robin scheduler of NSRC AXI4-Stream video sources onto one pixel write port.
module pxl_write_arbiter #(
  parameter int NSRC   = 2,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 20,
  parameter int PIXELS = 307200,
  parameter int GW     = $clog2(NSRC)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NSRC-1:0]          en_i,
  input  logic [NSRC-1:0]          s_tvalid_i,
  output logic [NSRC-1:0]          s_tready_o,
  input  logic [NSRC*DATA_W-1:0]   s_tdata_i,
  input  logic [NSRC-1:0]          s_tuser_i,
  input  logic                     pxl_hold_i,
  output logic [ADDR_W-1:0]        pxl_addr_o,
  output logic [DATA_W-1:0]        pxl_data_o,
  output logic                     pxl_en_o,
  output logic [GW-1:0]            grant_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     sof_err_o
);
  typedef enum logic [1:0] {IDLE, ARB, SYNC, STREAM} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic en_q, en_d, done_q, done_d, err_q, err_d;
  logic active, acc, sof, last, found;
  int idx;
  assign active = state_q == SYNC || state_q == STREAM;
  assign acc = active && s_tvalid_i[grant_q] && !pxl_hold_i;
  assign sof = s_tuser_i[grant_q];
  assign last = cnt_q == ADDR_W'(PIXELS - 1);
  // Everyone but the owner of an open frame is drained unconditionally.
  always_comb begin
    for (int i = 0; i < NSRC; i++) s_tready_o[i] = !(active && grant_q == GW'(i) && pxl_hold_i);
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    en_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    found = 1'b0;
    idx = 0;
    case (state_q)
      IDLE: state_d = |en_i ? ARB : IDLE;
      ARB: begin
        state_d = IDLE;
        for (int k = 1; k <= NSRC; k++) begin
          idx = (int'(grant_q) + k) % NSRC;
          if (!found && en_i[idx]) begin
            found = 1'b1;
            grant_d = GW'(idx);
            state_d = SYNC;
          end
        end
      end
      default: if (acc && (sof || state_q == STREAM)) begin
        en_d = 1'b1;
        data_d = s_tdata_i[grant_q*DATA_W +: DATA_W];
        addr_d = sof ? '0 : cnt_q;
        cnt_d = sof ? ADDR_W'(1) : cnt_q + ADDR_W'(1);
        err_d = sof && state_q == STREAM;
        state_d = STREAM;
        if (!sof && last) begin
          done_d = 1'b1;
          cnt_d = '0;
          state_d = ARB;
        end
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= GW'(NSRC - 1);
      cnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      en_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      en_q <= en_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign pxl_addr_o = addr_q;
  assign pxl_data_o = data_q;
  assign pxl_en_o = en_q;
  assign grant_o = grant_q;
  assign busy_o = state_q == STREAM;
  assign frame_done_o = done_q;
  assign sof_err_o = err_q;
endmodule
